// File: rtl/clockworks_pkg.sv
// Shared definitions for the clock/reset manager: mode codes, FSM states,
// and the counter-width helper used by the hold and debounce counters.
package clockworks_pkg;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_DIV  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // One spare bit above clog2 so a counter can hold n-1 and saturate cleanly.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/clock_reset_ctrl_step_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// registered one-cycle pulse on every accepted 0->1 level change.
module step_debouncer
  import clockworks_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_in,
  output logic rise_pulse
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // cnt_q counts consecutive synchronised samples that disagree with lvl_q.
  always_comb begin
    sync_d = {sync_q[0], raw_in};
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == DEB_LAST) begin
        lvl_d  = sync_q[1];
        rise_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/clock_reset_ctrl.sv
// SoC clock/reset manager: synchronised, timed, soft-extendable core reset and
// per-channel clock enables (free-run, divided, or single-step).
module clock_reset_ctrl
  import clockworks_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    soft_rst_req,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    step_btn,
  output logic                    resetn,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_s;
  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   resetn_q, resetn_d;
  logic [1:0]             mode_q, mode_d;
  logic [NUM_CH-1:0]      ce_q, ce_d;
  logic [NUM_CH-1:0]      div_ce;
  logic                   run_d;
  logic                   mode_chg;
  logic                   step_rise;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign rst_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == S_HOLD) begin
      if (!rst_s || soft_rst_req) begin
        hold_d = '0;
      end else if (hold_q == HOLD_LAST) begin
        state_d = S_RUN;
        hold_d  = '0;
      end else if (hold_q != '1) begin
        hold_d = hold_q + 1'b1;
      end
    end else if (soft_rst_req) begin
      state_d = S_HOLD;
      hold_d  = '0;
    end
  end

  // Outputs are registered from the next state so resetn, ready and ce all
  // change on the same edge as the state register.
  assign run_d    = (state_d == S_RUN);
  assign resetn_d = run_d;
  assign mode_d   = mode;
  assign mode_chg = (mode != mode_q);

  step_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step (
    .CLK       (CLK),
    .RESET     (RESET),
    .raw_in    (step_btn),
    .rise_pulse(step_rise)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio;
    logic             hit;

    assign ratio = div_ratio[i*DIV_W +: DIV_W];

    // Ratio is compared with >= so lowering it below the count fires at once.
    always_comb begin
      cnt_d = '0;
      hit   = 1'b0;
      if (run_d && !mode_chg && mode_q == MODE_DIV) begin
        if (cnt_q >= ratio) hit = 1'b1;
        else                cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign div_ce[i] = hit;
  end

  always_comb begin
    ce_d = '0;
    if (run_d && !mode_chg) begin
      case (mode_q)
        MODE_DIV:  ce_d = div_ce;
        MODE_STEP: ce_d = {NUM_CH{step_rise}};
        default:   ce_d = '1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q   <= '0;
      state_q  <= S_HOLD;
      hold_q   <= '0;
      resetn_q <= 1'b0;
      mode_q   <= MODE_RUN;
      ce_q     <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      resetn_q <= resetn_d;
      mode_q   <= mode_d;
      ce_q     <= ce_d;
    end
  end

  assign resetn = resetn_q;
  assign ready  = resetn_q;
  assign ce     = ce_q;

endmodule
